// File: rtl/shift_sequencer_pkg.sv
// ============================================================================
// Module   : shift_sequencer_pkg
// Brief    : Shared op encodings, FSM state encoding and default widths for
//            the multi-cycle shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_sequencer_pkg;

    localparam int WORD_DEFAULT = 32;
    localparam int STEP_DEFAULT = 2;

    typedef logic [1:0] op_t;
    localparam op_t OP_SLL  = 2'b00;
    localparam op_t OP_SRL  = 2'b01;
    localparam op_t OP_SRA  = 2'b10;
    localparam op_t OP_PASS = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module   : shift_step
// Brief    : Purely combinational shift of a word by 0..STEP positions,
//            left or right, with a selectable fill bit for vacated positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter  int WORD  = WORD_DEFAULT,
    parameter  int STEP  = STEP_DEFAULT,
    localparam int AMT_W = $clog2(STEP + 1)
) (
    input  logic [WORD-1:0]  i_data,
    input  logic             i_left,
    input  logic [AMT_W-1:0] i_amt,
    input  logic             i_fill,
    output logic [WORD-1:0]  o_data
);

    logic [WORD-1:0] w_mask;

    // The mask marks exactly the vacated positions so the fill bit can be ORed in.
    always_comb begin
        w_mask = '0;
        o_data = i_data;
        if (i_left) begin
            w_mask = ~({WORD{1'b1}} << i_amt);
            o_data = (i_data << i_amt) | (i_fill ? w_mask : '0);
        end else begin
            w_mask = ~({WORD{1'b1}} >> i_amt);
            o_data = (i_data >> i_amt) | (i_fill ? w_mask : '0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Brief    : Multi-cycle barrel-less shifter: applies up to STEP bit positions
//            per cycle until the captured shift amount is exhausted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WORD = WORD_DEFAULT,
    parameter int STEP = STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [4:0]      shamt,
    input  logic [WORD-1:0] in,
    output logic [WORD-1:0] out,
    output logic            busy,
    output logic            done
);

    localparam int         AMT_W  = $clog2(STEP + 1);
    localparam logic [4:0] c_step = 5'(STEP);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WORD-1:0] r_out;
    logic [WORD-1:0] w_out_nxt;
    logic [4:0]      r_rem;
    logic [4:0]      w_rem_nxt;
    op_t             r_op;
    op_t             w_op_nxt;

    logic [4:0]       w_step;
    logic [AMT_W-1:0] w_amt;
    logic             w_left;
    logic             w_fill;
    logic [WORD-1:0]  w_shifted;

    assign w_step = (r_rem < c_step) ? r_rem : c_step;
    assign w_amt  = AMT_W'(w_step);
    assign w_left = (r_op == OP_SLL);
    // During SRA the MSB of out never changes, so it still holds the operand's sign.
    assign w_fill = (r_op == OP_SRA) & r_out[WORD-1];

    shift_step #(
        .WORD (WORD),
        .STEP (STEP)
    ) u_shift_step (
        .i_data (r_out),
        .i_left (w_left),
        .i_amt  (w_amt),
        .i_fill (w_fill),
        .o_data (w_shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_rem   <= '0;
            r_op    <= OP_SLL;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_out_nxt = in;
                    w_op_nxt  = op;
                    w_rem_nxt = shamt;
                    if ((shamt == 5'd0) || (op == OP_PASS)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                w_out_nxt = w_shifted;
                w_rem_nxt = r_rem - w_step;
                if (r_rem == w_step) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out  = r_out;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Directed self-checking bench for shift_sequencer (WORD=32, STEP=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] in_d;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(
        .WORD (32),
        .STEP (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .shamt (shamt),
        .in    (in_d),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation: checks result, latency, busy length and post-done hold.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [4:0] s,
                         input logic [31:0] d, input logic [31:0] exp_out, input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        shamt = s;
        in_d  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        shamt = ~s;
        in_d  = ~d;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, "_lat"},  32'(lat),      32'(exp_lat));
        check({tag, "_out"},  out,           exp_out);
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_hold"}, out, exp_out);
    endtask

    initial begin
        logic [7:0] done_bits;
        int         done_cnt;
        logic [31:0] out_at_done;

        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        shamt = 5'd0;
        in_d  = 32'd0;
        #1 rst = 1'b1;
        #2;
        check("rst_out",  out,          32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_done", 32'(done),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("sll5",    2'b00, 5'd5,  32'h0000_0001, 32'h0000_0020, 4);
        do_op("sra31",   2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 17);
        do_op("srl31",   2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 17);
        do_op("sh0",     2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        do_op("pass",    2'b11, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        do_op("sra3pos", 2'b10, 5'd3,  32'h7FFF_FFF0, 32'h0FFF_FFFE, 3);
        do_op("srl4",    2'b01, 5'd4,  32'hF000_0000, 32'h0F00_0000, 3);
        do_op("sll1",    2'b00, 5'd1,  32'h8000_0001, 32'h0000_0002, 2);
        do_op("sra1",    2'b10, 5'd1,  32'h8000_0000, 32'hC000_0000, 2);

        // Second start pulsed mid-SHIFT must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b00; shamt = 5'd5; in_d = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; shamt = 5'd3; in_d = 32'hFFFF_0000;
        @(negedge clk);
        start = 1'b0;
        done_cnt    = 0;
        out_at_done = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                out_at_done = out;
            end
        end
        check("ign_done_cnt", 32'(done_cnt), 32'd1);
        check("ign_out",      out_at_done,   32'h0000_0020);

        // Held start: ignored in DONE, re-accepted on the first IDLE cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b00; shamt = 5'd2; in_d = 32'h0000_0003;
        done_bits = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            done_bits[i] = done;
        end
        start = 1'b0;
        check("held_pattern", {24'd0, done_bits}, 32'h0000_0092);
        check("held_out",     out,                32'h0000_000C);
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        start = 1'b1; op = 2'b00; shamt = 5'd20; in_d = 32'h0001_2345;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_out",  out,       32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("arst_no_done", 32'(done_cnt), 32'd0);
        do_op("post_rst", 2'b00, 5'd2, 32'h0000_0003, 32'h0000_000C, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
